spi_sniff_sched: RTL and testbench

Round-robin scheduler that time-shares the single SPI sniffer decoder between up to N_REQ requesters, each watching for its own 8-bit command code. It grants one requester at a time, loads the decoder's command input, pulses the decoder's start, waits for the decoder's ready, and returns the captured data byte tagged with the requester index. It sits between the host-side register/request logic and the sniffer decoder instance.

---
 rtl/spi_sniff_sched.sv | 106 ++++++++++
 tb/tb_spi_sniff_sched.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sniff_sched.sv
// spi_sniff_sched: round-robin scheduler sharing one SPI sniffer decoder; SPI_SNIFF_TMO_EN adds a WAIT timeout with decoder flush
module spi_sniff_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int TMO_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_cmd,
    input  logic [TMO_W-1:0]   timeout_cycles,
    output logic               dec_start,
    output logic [7:0]         dec_cmd,
    output logic               dec_flush,
    input  logic               dec_ready,
    input  logic [7:0]         dec_data,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [7:0]         rsp_data,
    output logic               rsp_timeout,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, START, WAIT, RESP, FLUSH} state_t;
    state_t state, state_n;
    logic [ID_W-1:0] last_grant, gnt_n, idx;
    logic [N_REQ-1:0][7:0] cmds;
    logic tmo_hit;

    assign cmds = req_cmd;

    // pick the first requesting index above last_grant, wrapping; walking down keeps the nearest one
    always_comb begin
        gnt_n = last_grant;
        idx = last_grant;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = ID_W'((int'(last_grant) + i) % N_REQ);
            if (req[idx]) gnt_n = idx;
        end
    end

    // next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = |req ? START : IDLE;
            START:   state_n = WAIT;
            WAIT:    state_n = dec_ready ? RESP : tmo_hit ? FLUSH : WAIT;
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // registered outputs decoded from the upcoming state, plus grant/data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_start  <= 1'b0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
            dec_cmd    <= '0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            dec_start <= state_n == START;
            rsp_valid <= state_n == RESP || state_n == FLUSH;
            busy      <= state_n != IDLE;
            if (state == IDLE && |req) begin
                rsp_id  <= gnt_n;
                dec_cmd <= cmds[gnt_n];
            end
            if (state == WAIT && dec_ready) rsp_data <= dec_data;
            else if (state_n == FLUSH)      rsp_data <= '0;
            if (state == RESP || state == FLUSH) last_grant <= rsp_id;
        end
    end

`ifdef SPI_SNIFF_TMO_EN
    logic [TMO_W-1:0] tmo_cnt;
    assign tmo_hit = state == WAIT && tmo_cnt == TMO_W'(1);

    // WAIT budget: loaded on entry, hits on the last allowed WAIT cycle; a zero load never hits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            dec_flush   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (state == START)                     tmo_cnt <= timeout_cycles;
            else if (state == WAIT && tmo_cnt != 0) tmo_cnt <= tmo_cnt - 1'b1;
            dec_flush   <= state_n == FLUSH;
            rsp_timeout <= state_n == FLUSH;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo  = ^timeout_cycles;
    assign tmo_hit     = 1'b0;
    assign dec_flush   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_spi_sniff_sched.sv
// tb_spi_sniff_sched: scoreboard bench with a behavioural decoder model
module tb_spi_sniff_sched;
    logic        clk = 0, rst_n = 1;
    logic [3:0]  req = 0;
    logic [31:0] req_cmd = 0;
    logic [15:0] timeout_cycles = 0;
    logic        dec_start, dec_flush, dec_ready = 0, rsp_valid, rsp_timeout, busy;
    logic [7:0]  dec_cmd, dec_data = 0, rsp_data;
    logic [1:0]  rsp_id;

    typedef struct packed {logic [1:0] id; logic [7:0] data; logic tmo;} exp_t;
    exp_t sb[$];
    exp_t e;
    int checks = 0, errors = 0;
    int cyc = 0, rsp_cnt = 0, flush_cnt = 0, start_cnt = 0;
    int dly = 20, cd = -1;
    bit manual = 0;

    spi_sniff_sched dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_cmd(req_cmd), .timeout_cycles(timeout_cycles),
        .dec_start(dec_start), .dec_cmd(dec_cmd), .dec_flush(dec_flush), .dec_ready(dec_ready),
        .dec_data(dec_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        rsp_cnt   <= rsp_cnt + int'(rsp_valid);
        flush_cnt <= flush_cnt + int'(dec_flush);
        start_cnt <= start_cnt + int'(dec_start);
    end

    // decoder model: answers dly cycles after start with data = cmd ^ 0x99; dly < 0 never answers
    initial forever begin
        @(posedge clk); #1;
        if (!manual) begin
            dec_ready = 0;
            if (dec_start) cd = dly;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    dec_ready = 1;
                    dec_data = dec_cmd ^ 8'h99;
                    cd = -1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // which: 0 = rsp_valid, 1 = dec_start; returns at the sampling point where it is seen
    task automatic wait_sig(input int which, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0 && rsp_valid) || (which == 1 && dec_start)) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        tick();
        rst_n = 0; req = 0; req_cmd = 0; timeout_cycles = 0;
        manual = 0; dec_ready = 0; dly = 20; cd = -1;
        sb.delete();
        repeat (2) tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        tick();
        rst_n = 0;
        @(negedge clk);
        checks++;
        if ({dec_start, dec_flush, rsp_valid, rsp_timeout, busy} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {dec_start, dec_flush, rsp_valid, rsp_timeout, busy});
        end
        checks++;
        if ({dec_cmd, rsp_data, rsp_id} !== 18'h0) begin
            errors++; $display("FAIL reset_data got %h want 0", {dec_cmd, rsp_data, rsp_id});
        end
        tick();
        rst_n = 1;
    endtask

    task automatic test_single();
        bit ok;
        int s, st0;
        do_reset();
        req_cmd[7:0] = 8'hA5;
        st0 = start_cnt;
        sb.push_back('{2'd0, 8'h3C, 1'b0});
        req = 4'b0001;
        wait_sig(1, 10, ok);
        s = cyc;
        checks++;
        if (!ok || dec_cmd !== 8'hA5) begin
            errors++; $display("FAIL single_start ok=%0d dec_cmd got %h want a5", ok, dec_cmd);
        end
        wait_sig(0, 40, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL single_rsp got no rsp_valid want one");
        end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_data, rsp_timeout} !== e) begin
                errors++; $display("FAIL single_rsp got %h want %h", {rsp_id, rsp_data, rsp_timeout}, e);
            end
            checks++;
            if (cyc - s !== 21) begin
                errors++; $display("FAIL single_latency got %0d want 21", cyc - s);
            end
        end
        tick();
        req = 0;
        repeat (5) tick();
        checks++;
        if (start_cnt - st0 !== 1) begin
            errors++; $display("FAIL single_starts got %0d want 1", start_cnt - st0);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int r0;
        logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] cmd [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        dly = 3;
        req_cmd = {cmd[3], cmd[2], cmd[1], cmd[0]};
        for (int k = 0; k < 5; k++) sb.push_back('{order[k], cmd[order[k]] ^ 8'h99, 1'b0});
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_sig(0, 30, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL rr_rsp%0d got no rsp_valid want one", k);
            end else begin
                e = sb.pop_front();
                if ({rsp_id, rsp_data, rsp_timeout} !== e) begin
                    errors++; $display("FAIL rr_rsp%0d got %h want %h", k, {rsp_id, rsp_data, rsp_timeout}, e);
                end
            end
            if (k == 0) begin
                r0 = cyc;
                wait_sig(1, 10, ok);
                checks++;
                if (!ok || cyc - r0 !== 2) begin
                    errors++; $display("FAIL rr_gap ok=%0d got %0d want 2", ok, cyc - r0);
                end
            end
        end
        tick();
        req = 0;
        repeat (8) tick();
    endtask

    task automatic test_stray();
        bit ok;
        int r0;
        do_reset();
        manual = 1;
        r0 = rsp_cnt;
        dec_ready = 1; dec_data = 8'hE1;
        tick();
        dec_ready = 0;
        repeat (2) tick();
        req_cmd[23:16] = 8'h11;
        req = 4'b0100;
        tick();
        dec_ready = 1; dec_data = 8'hE2;
        tick();
        dec_ready = 0;
        req_cmd[23:16] = 8'h22;
        repeat (4) tick();
        @(negedge clk);
        checks++;
        if (dec_cmd !== 8'h11 || busy !== 1'b1) begin
            errors++; $display("FAIL stray_cmd dec_cmd got %h want 11 busy got %b want 1", dec_cmd, busy);
        end
        checks++;
        if (rsp_cnt - r0 !== 0) begin
            errors++; $display("FAIL stray_rsp got %0d responses want 0", rsp_cnt - r0);
        end
        sb.push_back('{2'd2, 8'h44, 1'b0});
        tick();
        dec_ready = 1; dec_data = 8'h44;
        tick();
        dec_ready = 0;
        wait_sig(0, 5, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL stray_final got no rsp_valid want one");
        end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_data, rsp_timeout} !== e) begin
                errors++; $display("FAIL stray_final got %h want %h", {rsp_id, rsp_data, rsp_timeout}, e);
            end
        end
        tick();
        req = 0;
        manual = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int r0, f0;
        do_reset();
        dly = -1;
        req_cmd[7:0] = 8'h5A;
        req = 4'b0001;
        wait_sig(1, 10, ok);
        repeat (3) tick();
        r0 = rsp_cnt;
        f0 = flush_cnt;
        rst_n = 0;
        req = 0;
        @(negedge clk);
        checks++;
        if ({dec_start, dec_flush, rsp_valid, rsp_timeout, busy, dec_cmd, rsp_data, rsp_id} !== 23'h0) begin
            errors++; $display("FAIL midreset_out got %h want 0",
                {dec_start, dec_flush, rsp_valid, rsp_timeout, busy, dec_cmd, rsp_data, rsp_id});
        end
        tick();
        rst_n = 1;
        repeat (10) tick();
        checks++;
        if (rsp_cnt - r0 !== 0 || flush_cnt - f0 !== 0) begin
            errors++; $display("FAIL midreset_quiet got rsp=%0d flush=%0d want 0 0", rsp_cnt - r0, flush_cnt - f0);
        end
        dly = 5;
        req_cmd[23:16] = 8'h5A;
        sb.push_back('{2'd2, 8'h5A ^ 8'h99, 1'b0});
        req = 4'b0100;
        wait_sig(0, 20, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL midreset_next got no rsp_valid want one");
        end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_data, rsp_timeout} !== e) begin
                errors++; $display("FAIL midreset_next got %h want %h", {rsp_id, rsp_data, rsp_timeout}, e);
            end
        end
        tick();
        req = 0;
        repeat (3) tick();
    endtask

`ifdef SPI_SNIFF_TMO_EN
    task automatic test_timeout();
        bit ok;
        int s, f0;
        do_reset();
        dly = -1;
        timeout_cycles = 50;
        req_cmd[7:0] = 8'h33;
        f0 = flush_cnt;
        sb.push_back('{2'd0, 8'h00, 1'b1});
        req = 4'b0001;
        wait_sig(1, 10, ok);
        s = cyc;
        wait_sig(0, 80, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL tmo_rsp got no rsp_valid want one");
        end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_data, rsp_timeout} !== e || dec_flush !== 1'b1) begin
                errors++; $display("FAIL tmo_rsp got %h flush=%b want %h flush=1", {rsp_id, rsp_data, rsp_timeout}, dec_flush, e);
            end
            checks++;
            if (cyc - s !== 51) begin
                errors++; $display("FAIL tmo_latency got %0d want 51", cyc - s);
            end
        end
        tick();
        req = 0;
        repeat (3) tick();
        checks++;
        if (flush_cnt - f0 !== 1) begin
            errors++; $display("FAIL tmo_flushes got %0d want 1", flush_cnt - f0);
        end
    endtask

    task automatic test_race();
        bit ok;
        int s, f0;
        do_reset();
        manual = 1;
        timeout_cycles = 10;
        req_cmd[7:0] = 8'h12;
        f0 = flush_cnt;
        req = 4'b0001;
        wait_sig(1, 10, ok);
        s = cyc;
        repeat (10) tick();
        dec_ready = 1; dec_data = 8'h77;
        sb.push_back('{2'd0, 8'h77, 1'b0});
        tick();
        dec_ready = 0;
        wait_sig(0, 3, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL race_rsp got no rsp_valid want one");
        end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_data, rsp_timeout} !== e || cyc - s !== 11) begin
                errors++; $display("FAIL race_rsp got %h at %0d want %h at 11", {rsp_id, rsp_data, rsp_timeout}, cyc - s, e);
            end
        end
        tick();
        req = 0;
        manual = 0;
        repeat (60) tick();
        checks++;
        if (flush_cnt - f0 !== 0) begin
            errors++; $display("FAIL race_flush got %0d want 0", flush_cnt - f0);
        end
    endtask
`else
    task automatic test_no_timeout();
        bit ok;
        int f0;
        do_reset();
        timeout_cycles = 3;
        req_cmd[15:8] = 8'h0F;
        f0 = flush_cnt;
        sb.push_back('{2'd1, 8'h0F ^ 8'h99, 1'b0});
        req = 4'b0010;
        wait_sig(0, 40, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL notmo_rsp got no rsp_valid want one");
        end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_data, rsp_timeout} !== e || flush_cnt - f0 !== 0) begin
                errors++; $display("FAIL notmo_rsp got %h flushes=%0d want %h flushes=0",
                    {rsp_id, rsp_data, rsp_timeout}, flush_cnt - f0, e);
            end
        end
        tick();
        req = 0;
        repeat (3) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stray();
        test_reset_mid();
`ifdef SPI_SNIFF_TMO_EN
        test_timeout();
        test_race();
`else
        test_no_timeout();
`endif
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
